// File: rtl/cpm_fifo_pkg.sv
// Shared definitions for the CPM multi-word FIFOs: output-mode constants and
// the modular lane-address helper used by both the push-side and pop-side FIFOs.
package cpm_fifo_pkg;

    localparam string REG_OUT_TRUE  = "true";
    localparam string REG_OUT_FALSE = "false";

    // Address of lane `offset` starting at `base` in a circular store of `depth` words.
    function automatic int unsigned wrap_addr(
        input int unsigned base,
        input int unsigned offset,
        input int unsigned depth
    );
        return (base + offset) % depth;
    endfunction

endpackage

// File: rtl/cpm_simo_fifo_lane_sel.sv
// Combinational lane mux: presents up to DATA_MAX_N consecutive words starting at
// rd_pointer, zeroing any lane beyond the stored count or the caller's lane cap.
module cpm_simo_fifo_lane_sel
    import cpm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_MAX_N = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]            mem [RAM_DEPTH],
    input  logic [ADDR_WIDTH-1:0]            rd_pointer,
    input  logic [ADDR_WIDTH:0]              fifo_count,
    input  logic [ADDR_WIDTH:0]              lane_cap,
    output logic [DATA_MAX_N*DATA_WIDTH-1:0] lanes
);

    localparam int CW = ADDR_WIDTH + 1;

    always_comb begin
        // NOTE: the default assignment first keeps every bit driven on every path, so no latch is inferred.
        lanes = '0;
        for (int i = 0; i < DATA_MAX_N; i++) begin
            if ((CW'(i) < fifo_count) && (CW'(i) < lane_cap)) begin
                lanes[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem[ADDR_WIDTH'(wrap_addr(32'(rd_pointer), i, RAM_DEPTH))];
            end
        end
    end

endmodule

// File: rtl/cpm_simo_fifo.sv
// Single-input, multi-output FIFO: one word pushed per cycle, a batch of
// 1..DATA_MAX_N words popped per cycle onto a packed lane bus.
module cpm_simo_fifo
    import cpm_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 64,
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_NUMAW = 3,
    parameter int    DATA_MAX_N = 1 << DATA_NUMAW,
    parameter int    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter string REG_OUT    = REG_OUT_FALSE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Reset,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             pop,
    input  logic [DATA_NUMAW-1:0]            data_out_num,
    output logic [DATA_MAX_N*DATA_WIDTH-1:0] data_out,
    output logic                             data_out_vld,
    output logic                             pop_fail,
    output logic                             empty,
    output logic                             full,
    output logic [ADDR_WIDTH:0]              fifo_count,
    output logic [ADDR_WIDTH:0]              fifo_count_empty
);

    localparam int CW         = ADDR_WIDTH + 1;
    localparam int NW         = DATA_NUMAW + 1;
    localparam int BUS_W      = DATA_MAX_N * DATA_WIDTH;
    localparam bit REG_OUT_EN = (REG_OUT == REG_OUT_TRUE);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_pointer;
    logic [ADDR_WIDTH-1:0] rd_pointer;
    logic [NW-1:0]         pop_n;
    logic [CW-1:0]         pop_n_ext;
    logic [CW-1:0]         pop_dec;
    logic                  push_acc;
    logic                  pop_acc;
    logic [CW-1:0]         lane_cap;
    logic [BUS_W-1:0]      lanes;

    assign empty     = (fifo_count == '0);
    assign full      = (fifo_count == CW'(RAM_DEPTH));
    assign pop_n     = NW'(data_out_num) + NW'(1);
    assign pop_n_ext = CW'(pop_n);
    // Acceptance looks only at the current count: a same-cycle pop never frees room for a push.
    assign push_acc  = push && !full;
    assign pop_acc   = pop && (fifo_count >= pop_n_ext);
    assign pop_dec   = pop_acc ? pop_n_ext : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pointer       <= '0;
            rd_pointer       <= '0;
            fifo_count       <= '0;
            fifo_count_empty <= CW'(RAM_DEPTH);
            pop_fail         <= 1'b0;
        end else if (Reset) begin
            wr_pointer       <= '0;
            rd_pointer       <= '0;
            fifo_count       <= '0;
            fifo_count_empty <= CW'(RAM_DEPTH);
            pop_fail         <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_pointer <= wr_pointer + ADDR_WIDTH'(1);
            end
            if (pop_acc) begin
                rd_pointer <= ADDR_WIDTH'(wrap_addr(32'(rd_pointer), 32'(pop_n), RAM_DEPTH));
            end
            fifo_count       <= fifo_count + CW'(push_acc) - pop_dec;
            fifo_count_empty <= fifo_count_empty - CW'(push_acc) + pop_dec;
            pop_fail         <= pop && !pop_acc;
        end
    end

    // NOTE: the storage is cleared on reset because stale words must never appear on a lane; this costs a reset net per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
        end else if (Reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
        end else if (push_acc) begin
            mem[wr_pointer] <= data_in;
        end
    end

    cpm_simo_fifo_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_MAX_N (DATA_MAX_N),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_lane_sel (
        .mem        (mem),
        .rd_pointer (rd_pointer),
        .fifo_count (fifo_count),
        .lane_cap   (lane_cap),
        .lanes      (lanes)
    );

    generate
        if (REG_OUT_EN) begin : g_reg_out
            logic [BUS_W-1:0] data_q;
            logic             vld_q;

            // Capping at n zeroes the lanes above the batch; an accepted pop guarantees n <= fifo_count.
            assign lane_cap = pop_n_ext;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else if (Reset) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= pop_acc;
                    if (pop_acc) begin
                        data_q <= lanes;
                    end
                end
            end

            assign data_out     = data_q;
            assign data_out_vld = vld_q;
        end else begin : g_comb_out
            assign lane_cap     = CW'(DATA_MAX_N);
            assign data_out     = lanes;
            assign data_out_vld = !empty;
        end
    endgenerate

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(RAM_DEPTH));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (CW+1)'(fifo_count) + (CW+1)'(push_acc) >= (CW+1)'(pop_dec));

    a_count_sum: assert property (@(posedge clk) disable iff (rst)
        (CW+1)'(fifo_count) + (CW+1)'(fifo_count_empty) == (CW+1)'(RAM_DEPTH));

endmodule

// File: tb/tb_cpm_simo_fifo.sv
// Bench for cpm_simo_fifo: drives a combinational-output and a registered-output
// instance in lockstep and checks both against a queue-based reference model.
module tb_cpm_simo_fifo;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int NUMW  = 3;
    localparam int MAXN  = 8;
    localparam int DEPTH = 16;
    localparam int BUSW  = MAXN * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            Reset = 1'b0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic [NUMW-1:0] data_out_num = '0;

    logic [BUSW-1:0] dout_c, dout_r;
    logic            vld_c, vld_r, pf_c, pf_r;
    logic            empty_c, empty_r, full_c, full_r;
    logic [AW:0]     cnt_c, cnt_r, cnte_c, cnte_r;

    always #5 clk = ~clk;

    cpm_simo_fifo #(.REG_OUT("false")) dut_c (
        .clk(clk), .rst(rst), .Reset(Reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out_num(data_out_num), .data_out(dout_c),
        .data_out_vld(vld_c), .pop_fail(pf_c), .empty(empty_c), .full(full_c),
        .fifo_count(cnt_c), .fifo_count_empty(cnte_c)
    );

    cpm_simo_fifo #(.REG_OUT("true")) dut_r (
        .clk(clk), .rst(rst), .Reset(Reset), .push(push), .data_in(data_in),
        .pop(pop), .data_out_num(data_out_num), .data_out(dout_r),
        .data_out_vld(vld_r), .pop_fail(pf_r), .empty(empty_r), .full(full_r),
        .fifo_count(cnt_r), .fifo_count_empty(cnte_r)
    );

    wire [12:0] st_c = {empty_c, full_c, cnt_c, cnte_c, pf_c};
    wire [12:0] st_r = {empty_r, full_r, cnt_r, cnte_r, pf_r};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: stored words in arrival order plus the registered-mode output.
    logic [DW-1:0]   q[$];
    logic [BUSW-1:0] m_reg = '0;
    logic            m_vld_r = 1'b0;
    logic            m_pf = 1'b0;

    // Comb-mode outputs observed just before the edge, and what the model expects there.
    logic [BUSW-1:0] pre_c, pre_exp;
    logic            pre_vld_c, pre_exp_vld;

    function automatic logic [BUSW-1:0] head_lanes(input int k);
        logic [BUSW-1:0] r;
        r = '0;
        for (int i = 0; i < k && i < q.size(); i++) r[i*DW +: DW] = q[i];
        return r;
    endfunction

    function automatic logic [12:0] exp_status();
        int sz;
        sz = q.size();
        return {sz == 0, sz == DEPTH, 5'(sz), 5'(DEPTH - sz), m_pf};
    endfunction

    function automatic logic [BUSW-1:0] seq_lanes(input int first, input int count);
        logic [BUSW-1:0] r;
        r = '0;
        for (int i = 0; i < count; i++) r[i*DW +: DW] = DW'(first + i);
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        m_reg   = '0;
        m_vld_r = 1'b0;
        m_pf    = 1'b0;
    endtask

    task automatic cycle(input logic p, input logic [DW-1:0] d, input logic po,
                         input logic [NUMW-1:0] num, input logic rs);
        int  n, sz;
        logic pacc;
        @(negedge clk);
        push = p; data_in = d; pop = po; data_out_num = num; Reset = rs;
        #1;
        pre_c       = dout_c;
        pre_vld_c   = vld_c;
        pre_exp     = head_lanes(MAXN);
        pre_exp_vld = (q.size() != 0);
        @(posedge clk);
        #1;
        if (rs) begin
            model_clear();
        end else begin
            n    = int'(num) + 1;
            sz   = q.size();
            pacc = po && (sz >= n);
            m_pf    = po && !pacc;
            m_vld_r = pacc;
            if (pacc) begin
                m_reg = head_lanes(n);
                repeat (n) void'(q.pop_front());
            end
            if (p && sz < DEPTH) q.push_back(d);
        end
        push = 1'b0; pop = 1'b0; Reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        vectors++;
        if (cnt_c !== 5'd5) begin
            miscompares++; $display("FAIL pre_rst_count: got %0d want 5", cnt_c);
        end
        @(negedge clk); #2 rst = 1'b1; #1;
        model_clear();
        vectors++;
        if (st_c !== exp_status() || st_r !== exp_status()) begin
            miscompares++; $display("FAIL async_rst_status: c=%h r=%h want %h", st_c, st_r, exp_status());
        end
        vectors++;
        if ({dout_c, dout_r, vld_c, vld_r} !== '0 || cnte_c !== 5'd16) begin
            miscompares++; $display("FAIL async_rst_outputs: vld_c=%b vld_r=%b cnte=%0d", vld_c, vld_r, cnte_c);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        cycle(1'b1, 64'hDEAD, 1'b1, 3'd0, 1'b1);
        vectors++;
        if (st_c !== exp_status() || st_r !== exp_status() || cnt_c !== 5'd0 || cnte_r !== 5'd16) begin
            miscompares++; $display("FAIL sync_reset_status: c=%h r=%h want %h", st_c, st_r, exp_status());
        end
        vectors++;
        if ({dout_c, dout_r, vld_c, vld_r} !== '0) begin
            miscompares++; $display("FAIL sync_reset_outputs: vld_c=%b vld_r=%b", vld_c, vld_r);
        end
    endtask

    task automatic test_full_and_batches();
        for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, '0, 1'b0);
        cycle(1'b1, 64'h11, 1'b0, '0, 1'b0);
        vectors++;
        if (!full_c || !full_r || cnt_c !== 5'd16 || st_c !== exp_status() || st_r !== exp_status()) begin
            miscompares++; $display("FAIL full_drop: c=%h r=%h want %h", st_c, st_r, exp_status());
        end
        cycle(1'b0, '0, 1'b1, 3'd3, 1'b0);
        vectors++;
        if (pre_c !== seq_lanes(1, 8) || pre_vld_c !== 1'b1) begin
            miscompares++; $display("FAIL comb_lanes_full: got %h want %h", pre_c, seq_lanes(1, 8));
        end
        vectors++;
        if (dout_r !== seq_lanes(1, 4) || vld_r !== 1'b1 || cnt_r !== 5'd12 || cnt_c !== 5'd12) begin
            miscompares++; $display("FAIL pop4: got %h vld=%b cnt=%0d want %h", dout_r, vld_r, cnt_r, seq_lanes(1, 4));
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        vectors++;
        if (vld_r !== 1'b0 || dout_r !== seq_lanes(1, 4)) begin
            miscompares++; $display("FAIL vld_pulse_hold: vld=%b data=%h", vld_r, dout_r);
        end
        cycle(1'b0, '0, 1'b1, 3'd7, 1'b0);
        vectors++;
        if (pre_c !== seq_lanes(5, 8) || dout_r !== seq_lanes(5, 8) || cnt_c !== 5'd4 || cnt_r !== 5'd4) begin
            miscompares++; $display("FAIL pop8: got %h cnt=%0d want %h", dout_r, cnt_r, seq_lanes(5, 8));
        end
        cycle(1'b0, '0, 1'b1, 3'd7, 1'b0);
        vectors++;
        if (pf_c !== 1'b1 || pf_r !== 1'b1 || vld_r !== 1'b0 || cnt_c !== 5'd4 || st_r !== exp_status()) begin
            miscompares++; $display("FAIL pop_reject: pf=%b vld=%b cnt=%0d", pf_r, vld_r, cnt_r);
        end
        cycle(1'b0, '0, 1'b1, 3'd3, 1'b0);
        vectors++;
        if (pf_c !== 1'b0 || pre_c !== seq_lanes(13, 4) || dout_r !== seq_lanes(13, 4) || !empty_c || !empty_r) begin
            miscompares++; $display("FAIL pop_after_reject: pf=%b data=%h want %h", pf_c, dout_r, seq_lanes(13, 4));
        end
    endtask

    task automatic test_wrap();
        logic [BUSW-1:0] exp;
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 14; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd6, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd6, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd5, 1'b0);
        exp = seq_lanes(8'hA0, 6);
        vectors++;
        if (pre_c !== exp || dout_r !== exp || dout_r !== m_reg) begin
            miscompares++; $display("FAIL wrap_lanes: comb=%h reg=%h want %h", pre_c, dout_r, exp);
        end
        vectors++;
        if (cnt_c !== 5'd0 || cnt_r !== 5'd0 || st_c !== exp_status()) begin
            miscompares++; $display("FAIL wrap_count: cnt=%0d want 0", cnt_c);
        end
        // rd_pointer should now sit at 4: one more push/pop must return that word.
        cycle(1'b1, 64'h55, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd0, 1'b0);
        vectors++;
        if (pre_c !== seq_lanes(8'h55, 1) || dout_r !== seq_lanes(8'h55, 1)) begin
            miscompares++; $display("FAIL wrap_after: got %h want 55", dout_r[DW-1:0]);
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i + 32), 1'b0, '0, 1'b0);
        cycle(1'b1, 64'hEE, 1'b1, 3'd0, 1'b0);
        vectors++;
        if (cnt_c !== 5'd15 || cnt_r !== 5'd15 || dout_r !== seq_lanes(33, 1) || st_c !== exp_status()) begin
            miscompares++; $display("FAIL full_push_pop: cnt=%0d data=%h", cnt_c, dout_r[DW-1:0]);
        end
        cycle(1'b0, '0, 1'b1, 3'd7, 1'b0);
        cycle(1'b0, '0, 1'b1, 3'd4, 1'b0);
        cycle(1'b1, 64'h77, 1'b1, 3'd2, 1'b0);
        vectors++;
        if (pf_c !== 1'b1 || pf_r !== 1'b1 || cnt_c !== 5'd3 || cnt_r !== 5'd3 || vld_r !== 1'b0) begin
            miscompares++; $display("FAIL no_bypass: pf_c=%b pf_r=%b cnt=%0d want pf=1 cnt=3", pf_c, pf_r, cnt_c);
        end
        cycle(1'b0, '0, 1'b1, 3'd2, 1'b0);
        vectors++;
        if (dout_r !== m_reg || pre_c !== pre_exp || dout_r[3*DW-1 -: DW] !== 64'h77) begin
            miscompares++; $display("FAIL no_bypass_drain: got %h want %h", dout_r, m_reg);
        end
    endtask

    task automatic test_random();
        logic p, po, rs;
        for (int k = 0; k < 400; k++) begin
            p  = ($urandom_range(0, 9) < 6);
            po = ($urandom_range(0, 9) < 4);
            rs = ($urandom_range(0, 99) == 0);
            cycle(p, {$urandom, $urandom}, po, NUMW'($urandom_range(0, MAXN - 1)), rs);
            vectors++;
            if (pre_c !== pre_exp || pre_vld_c !== pre_exp_vld) begin
                miscompares++; $display("FAIL rnd_comb_lanes[%0d]: got %h want %h", k, pre_c, pre_exp);
            end
            vectors++;
            if (st_c !== exp_status() || st_r !== exp_status()) begin
                miscompares++; $display("FAIL rnd_status[%0d]: c=%h r=%h want %h", k, st_c, st_r, exp_status());
            end
            vectors++;
            if (dout_r !== m_reg || vld_r !== m_vld_r) begin
                miscompares++; $display("FAIL rnd_reg_out[%0d]: got %h vld=%b want %h vld=%b", k, dout_r, vld_r, m_reg, m_vld_r);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        test_reset();
        test_full_and_batches();
        test_wrap();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpm_simo_fifo.md
Name: cpm_simo_fifo

Overview:
Single-input, multi-output FIFO for the CPM datapath. It is the read-side counterpart of the multi-word-push FIFO.
- Producers push one word per cycle.
- A consumer pops a variable batch of 1..DATA_MAX_N words in one cycle, presented as a packed lane bus.
- Typical use: gathering serially produced results into a wide write for a downstream PE array or SRAM.

Parameters:
DATA_WIDTH, 64, width of one word
ADDR_WIDTH, 4, log2 of storage depth
DATA_NUMAW, 3, width of the pop-count field
DATA_MAX_N, 1<<DATA_NUMAW, max words per pop (must be <= RAM_DEPTH)
RAM_DEPTH, 1<<ADDR_WIDTH, storage depth in words
REG_OUT, "false", "true" = registered pop data; "false" = combinational lookahead

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
Reset  in  1  synchronous clear, active-high
push  in  1  write request
data_in  in  DATA_WIDTH  word to write
pop  in  1  batch read request
data_out_num  in  DATA_NUMAW  words to pop minus one (0 = 1 word)
data_out  out  DATA_MAX_N*DATA_WIDTH  lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
data_out_vld  out  1  lanes valid (see Behaviour)
pop_fail  out  1  pop rejected for insufficient words
empty  out  1  fifo_count == 0
full  out  1  fifo_count == RAM_DEPTH
fifo_count  out  ADDR_WIDTH+1  stored words
fifo_count_empty  out  ADDR_WIDTH+1  free slots, always RAM_DEPTH - fifo_count

Behaviour:
Reset:
- rst (async) and Reset (sync, at the clock edge) have identical effect.
- pointers = 0, fifo_count = 0, fifo_count_empty = RAM_DEPTH.
- memory = 0, data_out = 0, data_out_vld = 0, pop_fail = 0.
- Reset wins over a same-cycle push or pop; in-flight data is discarded.

Push:
- push_acc = push && !full.
- Accepted push writes mem[wr_pointer], then wr_pointer increments modulo RAM_DEPTH (natural wrap).
- A push while full is silently dropped; no state changes.
- No bypass: a same-cycle pop does not free space for the push.

Pop:
- n = data_out_num + 1, computed at DATA_NUMAW+1 bits.
- pop_acc = pop && (fifo_count >= n).
- Accepted pop: rd_pointer advances by n modulo RAM_DEPTH. Compute the wrap explicitly as (rd_pointer + i) mod RAM_DEPTH for every lane.
- Rejected pop (pop && fifo_count < n): pointers and counts unchanged; pop_fail = 1 for one cycle (registered, visible the following cycle).
- A pop never consumes a word pushed in the same cycle.

Counts:
- Next fifo_count = fifo_count + push_acc - (pop_acc ? n : 0).
- fifo_count_empty is updated by the mirror expression.
- empty and full are combinational from fifo_count.

REG_OUT="false":
- Each lane i is mem[(rd_pointer+i) mod RAM_DEPTH] when i < fifo_count, else 0.
- data_out_vld = !empty, combinational.
- The consumer samples the lanes in the same cycle it asserts pop.

REG_OUT="true":
- On pop_acc, at the clock edge: lanes 0..n-1 load mem[(rd_pointer+i) mod RAM_DEPTH]; lanes n..DATA_MAX_N-1 load 0; data_out_vld = 1.
- On any other cycle: data_out holds its value and data_out_vld = 0.
- Latency: 1 cycle.

Invariants:
- fifo_count never exceeds RAM_DEPTH and never underflows.
- Assertions required on both, and on fifo_count + fifo_count_empty == RAM_DEPTH.

Decomposition:
- Shared package cpm_fifo_pkg holds:
  - the REG_OUT string constants;
  - a function for the modular lane-address calculation (wrap helper), shared with the multi-word-push FIFO.
- One natural sub-module: cpm_simo_fifo_lane_sel. It is the combinational lane mux producing DATA_MAX_N words from rd_pointer, fifo_count and the memory array, including lane zeroing.
- Counters, pointers and the optional output register stay in the top module.

Test Plan:
1. Assert rst mid-stream with 5 words stored -> immediately empty=1, fifo_count=0, fifo_count_empty=16, data_out=0; Reset (sync) gives the same result at the next edge.
2. Push 0x01..0x10 (16 words), then push 0x11 -> full=1, fifo_count=16, 0x11 dropped; a later pop n=1 returns 0x01.
3. From full, pop data_out_num=3 -> lanes 0..3 = 0x01..0x04, lanes 4..7 = 0 (REG_OUT="true", vld pulses once), fifo_count=12. Then pop data_out_num=7 -> lanes = 0x05..0x0C, fifo_count=4.
4. With fifo_count=4, pop data_out_num=7 -> rejected, pop_fail=1 for one cycle, fifo_count stays 4, next pop n=4 returns 0x0D..0x10.
5. Wrap: rd_pointer=14, wr_pointer=14; push 0xA0..0xA5; pop data_out_num=5 -> lanes 0..5 = 0xA0..0xA5 (addresses 14,15,0..3), rd_pointer=4, fifo_count=0.
6. Simultaneous events:
   - full, push 0xEE + pop n=1 -> push dropped, fifo_count=15.
   - fifo_count=2, push + pop n=3 -> pop rejected (no bypass), pop_fail=1, fifo_count=3.
   - Check both with REG_OUT="false" and with REG_OUT="true".
